// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        REPORT,
        HOLD,
        RELEASE
    } scan_state_t;

    typedef logic [3:0] key_code_t;

    localparam logic [3:0] ROW_ONEHOT [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Lowest pressed column wins when several keys share the frozen row.
    function automatic logic [1:0] lowest_col(input logic [3:0] c);
        if (c[0])      return 2'd0;
        else if (c[1]) return 2'd1;
        else if (c[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync_2ff.sv
// Parameterized-width two-flop synchronizer, synchronous active-high reset to zero.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row drive, synchronized column sampling, press/release debounce.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                                          : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SETTLE_CYCLES < 3 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_param_check
        $error("keypad_scan_ctrl: parameter below its minimum");
    end

    logic [3:0]       cols_s;
    scan_state_t      state_q;
    logic [1:0]       row_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       snap_q;
    key_code_t        key_code_q;
    logic             key_valid_q;
    logic             busy_q;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    // rep_q counts cycles since the last strobe; rep_first_q selects the initial delay.
    logic [REP_W-1:0] rep_q;
    logic             rep_first_q;
`endif

    sync_2ff #(
        .WIDTH(4)
    ) u_cols_sync (
        .clk_i  (clk),
        .reset_i(reset),
        .d_i    (cols),
        .q_o    (cols_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            row_idx_q   <= '0;
            cnt_q       <= '0;
            snap_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q <= '0;
                        if (cols_s != '0) begin
                            snap_q  <= cols_s;
                            state_q <= DEBOUNCE;
                            busy_q  <= 1'b1;
                        end else begin
                            row_idx_q <= row_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (cols_s != snap_q) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q     <= REPORT;
                        cnt_q       <= '0;
                        key_valid_q <= 1'b1;
                        key_code_q  <= {row_idx_q, lowest_col(snap_q)};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REPORT: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                    rep_q       <= REP_W'(1);
                    rep_first_q <= 1'b1;
`endif
                end
                HOLD: begin
                    if (cols_s == '0) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_q       <= '0;
                        rep_first_q <= 1'b1;
                    end else if (rep_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                        key_valid_q <= 1'b1;
                        rep_q       <= '0;
                        rep_first_q <= 1'b0;
                    end else begin
                        rep_q <= rep_q + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    if (cols_s != '0) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_q       <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= SCAN;
                        cnt_q     <= '0;
                        row_idx_q <= row_idx_q + 2'd1;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= SCAN;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rows      = ROW_ONEHOT[row_idx_q];
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: keypad matrix model, dwell-time reference model, vectors, random stress.
module tb_keypad_scan_ctrl;

    localparam int SETTLE  = 4;
    localparam int DEB     = 8;
    localparam int RDELAY  = 64;
    localparam int RPERIOD = 16;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam int PH_SCAN = 0;
    localparam int PH_DEB  = 1;
    localparam int PH_REP  = 2;
    localparam int PH_HOLD = 3;
    localparam int PH_REL  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        busy;
    logic [15:0] keys;

    int errors;
    int checks;
    int n;
    int strobes;
    int first_n;
    logic [3:0] last_code;

    // Reference model: phase plus the edge index at which it was entered.
    int         m_ph;
    int         m_row;
    int         m_t0;
    int         m_last;
    bit         m_first;
    logic [3:0] m_s1, m_s2, m_snap, m_code;
    logic       m_valid;

    typedef struct {
        logic [15:0] keys;
        int          row;
        int          hold;
        int          exp_strobes;
        logic [3:0]  exp_code;
        logic [3:0]  exp_rows_after;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    // Keypad matrix: key (r,c) is bit r*4+c and connects row r to column c.
    always_comb begin
        cols = '0;
        for (int r = 0; r < 4; r++)
            if (rows[r] === 1'b1) cols = cols | keys[r*4 +: 4];
    end

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_PERIOD  (RPERIOD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cols     (cols),
        .rows     (rows),
        .key_code (key_code),
        .key_valid(key_valid),
        .busy     (busy)
    );

    function automatic int low_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_step(input logic rst_v, input logic [3:0] c);
        logic [3:0] cs;
        int dwell;
        m_valid = 1'b0;
        if (rst_v) begin
            m_ph = PH_SCAN; m_row = 0; m_t0 = n; m_code = '0;
            m_s1 = '0; m_s2 = '0; m_snap = '0;
            return;
        end
        cs    = m_s2;
        m_s2  = m_s1;
        m_s1  = c;
        dwell = n - m_t0;
        case (m_ph)
            PH_SCAN:
                if (dwell == SETTLE) begin
                    m_t0 = n;
                    if (cs != 0) begin m_snap = cs; m_ph = PH_DEB; end
                    else m_row = (m_row + 1) % 4;
                end
            PH_DEB:
                if (cs != m_snap) begin m_ph = PH_SCAN; m_t0 = n; end
                else if (dwell == DEB) begin
                    m_ph = PH_REP; m_t0 = n; m_valid = 1'b1;
                    m_code = 4'(m_row * 4 + low_idx(m_snap));
                end
            PH_REP: begin
                m_ph = PH_HOLD; m_t0 = n; m_last = n - 1; m_first = 1'b1;
            end
            PH_HOLD:
                if (cs == 0) begin m_ph = PH_REL; m_t0 = n; end
                else if (REP_EN && (n - m_last) == (m_first ? RDELAY : RPERIOD)) begin
                    m_valid = 1'b1; m_last = n; m_first = 1'b0;
                end
            PH_REL:
                if (cs != 0) begin m_ph = PH_HOLD; m_t0 = n; m_last = n; m_first = 1'b1; end
                else if (dwell == DEB) begin
                    m_ph = PH_SCAN; m_t0 = n; m_row = (m_row + 1) % 4;
                end
            default: m_ph = PH_SCAN;
        endcase
    endtask

    task automatic tick(input logic rst_v);
        logic [3:0] c;
        @(negedge clk);
        reset = rst_v;
        #1 c = cols;
        @(posedge clk);
        n++;
        model_step(rst_v, c);
        #1;
        check("rows", rows, 4'(1 << m_row));
        check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        check("key_code", key_code, m_code);
        check("busy", {3'b0, busy}, {3'b0, m_ph != PH_SCAN});
        if (key_valid === 1'b1) begin
            if (strobes == 0) first_n = n;
            strobes++;
            last_code = key_code;
        end
    endtask

    task automatic wait_row(input int r);
        int guard;
        guard = 0;
        while (rows === 4'(1 << r) && guard < 40) begin tick(1'b0); guard++; end
        while (rows !== 4'(1 << r) && guard < 80) begin tick(1'b0); guard++; end
        check($sformatf("wait_row%0d", r), rows, 4'(1 << r));
    endtask

    task automatic wait_busy(input string name);
        int guard;
        guard = 0;
        while (busy !== 1'b1 && guard < 10) begin tick(1'b0); guard++; end
        check(name, {3'b0, busy}, 4'd1);
    endtask

    initial begin
        int p;
        int guard;
        logic [15:0] pat;
        errors = 0; checks = 0; n = 0; strobes = 0; first_n = 0; last_code = '0;
        keys = '0; reset = 1'b1;
        m_ph = PH_SCAN; m_row = 0; m_t0 = 0; m_last = 0; m_first = 1'b1;
        m_s1 = '0; m_s2 = '0; m_snap = '0; m_code = '0; m_valid = 1'b0;

        tick(1'b1);
        tick(1'b1);

        // Idle sweep: each row held SETTLE cycles, no activity.
        for (int k = 1; k <= 40; k++) begin
            tick(1'b0);
            check("sweep_rows", rows, 4'(1 << ((k / 4) % 4)));
            check("sweep_valid", {3'b0, key_valid}, 4'd0);
            check("sweep_busy", {3'b0, busy}, 4'd0);
        end

        tbl[0] = '{16'h0040, 1, 30,  1,               4'h6, 4'b0100};
        tbl[1] = '{16'hA000, 3, 30,  1,               4'hD, 4'b0001};
        tbl[2] = '{16'h0001, 0, 20,  1,               4'h0, 4'b0010};
        tbl[3] = '{16'h0F00, 2, 25,  1,               4'h8, 4'b1000};
        tbl[4] = '{16'h0890, 1, 30,  1,               4'h4, 4'b0100};
        tbl[5] = '{16'h0200, 2, 100, REP_EN ? 3 : 1,  4'h9, 4'b1000};

        for (int i = 0; i < 6; i++) begin
            wait_row(tbl[i].row);
            keys    = tbl[i].keys;
            strobes = 0;
            first_n = -1;
            p       = n + 1;
            for (int h = 0; h < tbl[i].hold; h++) tick(1'b0);
            keys = '0;
            for (int h = 0; h < 12; h++) tick(1'b0);
            check($sformatf("vec%0d_strobes", i), 4'(strobes), 4'(tbl[i].exp_strobes));
            check($sformatf("vec%0d_code", i), last_code, tbl[i].exp_code);
            check($sformatf("vec%0d_rows_after", i), rows, tbl[i].exp_rows_after);
            check($sformatf("vec%0d_latency", i),
                  {3'b0, (first_n >= p) && (first_n - p <= 2 + SETTLE + DEB + 1)}, 4'd1);
        end

        // Bounce inside DEBOUNCE, then a steady press.
        wait_row(1);
        keys = 16'h0040;
        wait_busy("bounce_enter");
        strobes = 0;
        for (int k = 0; k < 7; k++) begin
            keys = (k % 2 == 0) ? 16'h0000 : 16'h0040;
            repeat (3) tick(1'b0);
        end
        check("bounce_quiet", 4'(strobes), 4'd0);
        keys  = 16'h0040;
        guard = 0;
        while (strobes == 0 && guard < 50) begin tick(1'b0); guard++; end
        check("bounce_strobe", 4'(strobes), 4'd1);
        check("bounce_code", last_code, 4'h6);
        keys = '0;
        repeat (12) tick(1'b0);

        // Reset while debouncing a press on row 0.
        wait_row(0);
        keys = 16'h0001;
        wait_busy("rst_enter");
        tick(1'b1);
        check("rst_rows", rows, 4'b0001);
        check("rst_code", key_code, 4'h0);
        check("rst_busy", {3'b0, busy}, 4'd0);
        check("rst_valid", {3'b0, key_valid}, 4'd0);
        keys = '0;
        repeat (12) tick(1'b0);

        // Random presses with flicker, random gaps and occasional resets.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 19) == 0) tick(1'b1);
            pat = $urandom_range(0, 1) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            for (int h = 0; h < int'($urandom_range(0, 40)); h++) begin
                keys = ($urandom_range(0, 9) == 0) ? 16'h0000 : pat;
                tick(1'b0);
            end
            keys = '0;
            repeat ($urandom_range(0, 25)) tick(1'b0);
        end
        repeat (20) tick(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
